unpacker32to8: RTL and testbench
================================

UNPACKER32TO8 -- requirements
Module: unpacker32to8

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32: input word width in bits.
REQ-002 SHALL have parameter BE_LEN, default 4: byte-enable width, one bit per input byte, equal to DATA_LEN/8.
REQ-003 SHALL have parameter LVDS_LEN, default 8: output byte width.
REQ-004 SHALL have parameter MSB_FIRST, default 0: 0 = byte 0 (bits 7:0) emitted first; 1 = byte BE_LEN-1 emitted first.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port valid_in, input, 1 bit: upstream word valid.
REQ-008 SHALL have port ready_in, output, 1 bit: block accepts a word this cycle.
REQ-009 SHALL have port data_in, input, DATA_LEN bits: upstream word.
REQ-010 SHALL have port be_in, input, BE_LEN bits: per-byte enable of data_in.
REQ-011 SHALL have port last_in, input, 1 bit: word ends a frame.
REQ-012 SHALL have port valid_out, output, 1 bit: data_out valid (strobe toward the LVDS transmitter).
REQ-013 SHALL have port ready_out, input, 1 bit: downstream accepts a byte.
REQ-014 SHALL have port data_out, output, LVDS_LEN bits: current byte.
REQ-015 SHALL have port last_out, output, 1 bit: current byte is the final byte of a last_in word.
REQ-016 SHALL have port byte_cnt, output, 16 bits: count of transferred bytes.

Function
REQ-017 SHALL have two states: IDLE (no word held) and SHIFT (word held, one or more enabled bytes remaining).
REQ-018 SHALL accept a word on any rising edge where valid_in && ready_in.
REQ-019 SHALL transfer a byte on any rising edge where valid_out && ready_out.
REQ-020 SHALL drive ready_in = !rst && (IDLE || (SHIFT && remaining mask has exactly one bit set && ready_out)), giving zero-bubble back-to-back words.
REQ-021 SHALL, on accept with be_in != 0, register data_in, be_in (as the remaining mask) and last_in, and enter or stay in SHIFT.
REQ-022 SHALL, on accept with be_in == 0, discard the word, including last_in, and end in IDLE (IDLE -> IDLE, or SHIFT -> IDLE after the final byte).
REQ-023 SHALL drive valid_out = (state == SHIFT); data_out SHALL be the held byte at the lowest set mask bit (MSB_FIRST=0) or the highest set mask bit (MSB_FIRST=1), muxed from registers only.
REQ-024 SHALL, on a transfer, clear that mask bit; when the mask becomes zero with no simultaneous accept, SHALL go to IDLE.
REQ-025 SHALL give a latency of one cycle: a word accepted at edge N presents its first byte in the cycle after edge N.
REQ-026 SHALL hold data_out, valid_out and last_out stable while valid_out && !ready_out.
REQ-027 SHALL drive last_out = valid_out && held last flag && remaining mask has exactly one bit set.
REQ-028 SHALL skip disabled bytes with no idle cycle; non-contiguous enables (e.g. 4'b1010) SHALL emit only bytes 1 and 3.
REQ-029 SHALL increment byte_cnt by 1 per transfer, modulo 2^16 (0xFFFF -> 0x0000).
REQ-030 SHALL ignore data_in, be_in and last_in when no accept occurs.

Reset
REQ-031 SHALL, while rst is high at a rising edge, set state IDLE, clear mask and last flag, and set byte_cnt = 0.
REQ-032 SHALL hold valid_out = 0, last_out = 0, ready_in = 0 and data_out = 0 while rst is high.
REQ-033 SHALL, on reset asserted mid-word, discard remaining bytes; after rst falls, no stale byte SHALL appear and ready_in SHALL be 1 on the first cycle.

Verification
REQ-034 SHALL cover: ready_out = 1, word 0x44332211 with be 4'hF, MSB_FIRST = 0 -> bytes 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles; byte_cnt = 4.
REQ-035 SHALL cover: be 4'b0101 on 0xDDCCBBAA, then be 4'h0 with last_in = 1 -> only 0xAA, 0xCC emitted; no last_out; word 2 consumed in one cycle.
REQ-036 SHALL cover: two back-to-back full words with valid_in held high and ready_out = 1 -> 8 bytes on 8 consecutive cycles with no valid_out gap; ready_in high on cycle 4.
REQ-037 SHALL cover: ready_out low for 3 cycles mid-word -> data_out held unchanged, no byte lost or duplicated, ready_in = 0 during the stall.
REQ-038 SHALL cover: last_in = 1 with be 4'b0110, MSB_FIRST = 1 -> byte 2 then byte 1, with last_out = 1 only on byte 1.
REQ-039 SHALL cover: rst pulsed after 2 of 4 bytes, and byte_cnt preloaded by 65535 transfers then 1 more -> all outputs 0 after reset and no remaining bytes emitted; byte_cnt wraps to 0x0000.

Source files
------------

// File: rtl/unpacker32to8.sv
// Unpacks byte-enabled words into a stream of bytes for the LVDS transmitter.
// Disabled bytes are skipped without bubbles; the next word loads on the final byte.
module unpacker32to8 #(
  parameter int DATA_LEN  = 32,
  parameter int BE_LEN    = 4,
  parameter int LVDS_LEN  = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic [BE_LEN-1:0]   be_in,
  input  logic                last_in,
  output logic                valid_out,
  input  logic                ready_out,
  output logic [LVDS_LEN-1:0] data_out,
  output logic                last_out,
  output logic [15:0]         byte_cnt
);

  localparam logic IDLE  = 1'b0;
  localparam logic SHIFT = 1'b1;

  logic                state;
  logic [DATA_LEN-1:0] data_q;
  logic [BE_LEN-1:0]   mask_q;
  logic                last_q;
  logic [BE_LEN-1:0]   sel_oh;
  logic [BE_LEN-1:0]   mask_nx;
  logic [LVDS_LEN-1:0] sel_byte;
  logic                one_left;
  logic                accept;
  logic                xfer;

  // Later hits overwrite earlier ones, so scan order picks lowest or highest.
  always_comb begin
    int k;
    k        = 0;
    sel_oh   = '0;
    sel_byte = '0;
    for (int i = 0; i < BE_LEN; i++) begin
      k = (MSB_FIRST != 0) ? i : BE_LEN - 1 - i;
      if (mask_q[k]) begin
        sel_oh    = '0;
        sel_oh[k] = 1'b1;
        sel_byte  = data_q[k*LVDS_LEN +: LVDS_LEN];
      end
    end
  end

  assign mask_nx  = mask_q & ~sel_oh;
  assign one_left = (mask_q != '0) &&
                    ((mask_q & (mask_q - {{(BE_LEN-1){1'b0}}, 1'b1})) == '0);

  assign valid_out = !rst && (state == SHIFT);
  assign ready_in  = !rst && ((state == IDLE) ||
                     ((state == SHIFT) && one_left && ready_out));
  assign data_out  = valid_out ? sel_byte : '0;
  assign last_out  = valid_out && last_q && one_left;

  assign accept = valid_in && ready_in;
  assign xfer   = valid_out && ready_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_q   <= '0;
      mask_q   <= '0;
      last_q   <= 1'b0;
      byte_cnt <= '0;
    end else begin
      if (xfer)
        byte_cnt <= byte_cnt + 16'd1;
      if (accept) begin
        if (be_in != '0) begin
          state  <= SHIFT;
          data_q <= data_in;
          mask_q <= be_in;
          last_q <= last_in;
        end else begin
          state  <= IDLE;
          mask_q <= '0;
          last_q <= 1'b0;
        end
      end else if (xfer) begin
        mask_q <= mask_nx;
        if (mask_nx == '0)
          state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_unpacker32to8.sv
// Scoreboard bench for unpacker32to8, LSB-first and MSB-first instances
// driven in lockstep from one stimulus stream.
module tb_unpacker32to8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  be_in;
  logic        last_in;
  logic        ready_out;

  logic        ready_in0, valid_out0, last_out0;
  logic [7:0]  data_out0;
  logic [15:0] byte_cnt0;
  logic        ready_in1, valid_out1, last_out1;
  logic [7:0]  data_out1;
  logic [15:0] byte_cnt1;

  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [15:0] model_cnt = '0;
  int          xfers = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        acc_ok = 1'b0;
  logic        rand_ro = 1'b0;

  always #5 clk = ~clk;

  unpacker32to8 #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in0),
    .data_in(data_in), .be_in(be_in), .last_in(last_in),
    .valid_out(valid_out0), .ready_out(ready_out), .data_out(data_out0),
    .last_out(last_out0), .byte_cnt(byte_cnt0)
  );

  unpacker32to8 #(.MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in1),
    .data_in(data_in), .be_in(be_in), .last_in(last_in),
    .valid_out(valid_out1), .ready_out(ready_out), .data_out(data_out1),
    .last_out(last_out1), .byte_cnt(byte_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h want %h", tag, got, exp);
  endtask

  task automatic push_word(input logic [31:0] d, input logic [3:0] be,
                           input logic last);
    int lo, hi;
    lo = -1;
    hi = -1;
    for (int i = 0; i < 4; i++)
      if (be[i]) begin
        if (lo < 0) lo = i;
        hi = i;
      end
    for (int i = 0; i < 4; i++)
      if (be[i]) q0.push_back({last && (i == hi), d[i*8 +: 8]});
    for (int i = 3; i >= 0; i--)
      if (be[i]) q1.push_back({last && (i == lo), d[i*8 +: 8]});
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [3:0] be,
                      input logic last);
    bit done;
    done     = 1'b0;
    valid_in = 1'b1;
    data_in  = d;
    be_in    = be;
    last_in  = last;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      if (acc_ok) done = 1'b1;
    end
    #1;
    chk("accept_timeout", 32'(done), 32'd1);
    if (done) push_word(d, be, last);
    valid_in = 1'b0;
    data_in  = $urandom;
    be_in    = 4'($urandom);
    last_in  = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q0.size() != 0; i++) @(posedge clk);
    chk("drain_timeout", 32'(q0.size() == 0), 32'd1);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid0", 32'(valid_out0), 32'd0);
      chk("rst_valid1", 32'(valid_out1), 32'd0);
      chk("rst_last0", 32'(last_out0), 32'd0);
      chk("rst_ready0", 32'(ready_in0), 32'd0);
      chk("rst_ready1", 32'(ready_in1), 32'd0);
      chk("rst_data0", 32'(data_out0), 32'd0);
      chk("rst_data1", 32'(data_out1), 32'd0);
      model_cnt = '0;
      acc_ok    = 1'b0;
    end else begin
      chk("cnt0", 32'(byte_cnt0), 32'(model_cnt));
      chk("cnt1", 32'(byte_cnt1), 32'(model_cnt));
      chk("valid0", 32'(valid_out0), 32'(q0.size() != 0));
      chk("valid1", 32'(valid_out1), 32'(q1.size() != 0));
      chk("ready0", 32'(ready_in0),
          32'(q0.size() == 0 || (q0.size() == 1 && ready_out)));
      chk("ready1", 32'(ready_in1),
          32'(q1.size() == 0 || (q1.size() == 1 && ready_out)));
      acc_ok = valid_in && ready_in0;
      if (q0.size() != 0) begin
        chk("data0", 32'(data_out0), 32'(q0[0][7:0]));
        chk("last0", 32'(last_out0), 32'(q0[0][8]));
        if (ready_out) begin
          void'(q0.pop_front());
          model_cnt = model_cnt + 16'd1;
          xfers++;
        end
      end
      if (q1.size() != 0) begin
        chk("data1", 32'(data_out1), 32'(q1[0][7:0]));
        chk("last1", 32'(last_out1), 32'(q1[0][8]));
        if (ready_out) void'(q1.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ro) begin
      #1;
      ready_out = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int start;
    rst       = 1'b1;
    valid_in  = 1'b0;
    data_in   = '0;
    be_in     = '0;
    last_in   = 1'b0;
    ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Full word, LSB first, four consecutive bytes.
    send(32'h44332211, 4'hF, 1'b0);
    drain();
    chk("cnt_after_first", 32'(byte_cnt0), 32'd4);
    @(posedge clk); #1;

    // Sparse enables, then an empty last word.
    send(32'hDDCCBBAA, 4'b0101, 1'b0);
    send(32'h12345678, 4'h0, 1'b1);
    drain();
    @(posedge clk); #1;

    // Two back-to-back full words.
    send(32'h04030201, 4'hF, 1'b1);
    send(32'h08070605, 4'hF, 1'b0);
    drain();
    @(posedge clk); #1;

    // Downstream stall mid-word.
    send(32'hA4A3A2A1, 4'hF, 1'b0);
    @(posedge clk); #1;
    ready_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ready_out = 1'b1;
    drain();
    @(posedge clk); #1;

    // Last word with a middle-pair enable.
    send(32'hEEDDCCBB, 4'b0110, 1'b1);
    send(32'hF0E0D0C0, 4'b1010, 1'b1);
    drain();
    @(posedge clk); #1;

    // Random words with random downstream backpressure.
    rand_ro = 1'b1;
    for (int i = 0; i < 30; i++)
      send($urandom, 4'($urandom), 1'($urandom));
    rand_ro = 1'b0;
    @(posedge clk); #1;
    ready_out = 1'b1;
    drain();
    @(posedge clk); #1;

    // Reset after two of four bytes.
    start = xfers;
    send(32'h55667788, 4'hF, 1'b1);
    for (int i = 0; i < 50 && xfers < start + 2; i++) @(posedge clk);
    #1;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_ready", 32'(ready_in0), 32'd1);
    chk("post_rst_valid", 32'(valid_out0), 32'd0);
    chk("post_rst_cnt", 32'(byte_cnt0), 32'd0);
    @(posedge clk); #1;

    // 65535 transfers then one more wraps the counter.
    for (int i = 0; i < 16383; i++)
      send(32'($urandom), 4'hF, 1'b0);
    send(32'hCAFEF00D, 4'b0111, 1'b0);
    drain();
    chk("cnt_ffff", 32'(byte_cnt0), 32'h0000FFFF);
    @(posedge clk); #1;
    send(32'h000000AB, 4'b0001, 1'b1);
    drain();
    chk("cnt_wrap0", 32'(byte_cnt0), 32'h00000000);
    chk("cnt_wrap1", 32'(byte_cnt1), 32'h00000000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
